// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall sequencer: StallBus layout,
// Stop/NoStop encoding, the canned stall patterns and the FSM state encoding.
package pipe_stall_ctrl_pkg;

    // StallBus width and per-bit meaning
    localparam int STALL_BUS_W = 6;
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Stage index constants, bit i of the StallBus drives stage i
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Hold every stage from PC up to and including last_stage. The first
    // stage above it sees stall[i]=1 / stall[i+1]=0 and takes a bubble.
    function automatic logic [STALL_BUS_W-1:0] hold_through(input int last_stage);
        logic [STALL_BUS_W-1:0] pattern;
        pattern = {STALL_BUS_W{NOSTOP}};
        for (int i = 0; i < STALL_BUS_W; i++) begin
            if (i <= last_stage) begin
                pattern[i] = STOP;
            end
        end
        return pattern;
    endfunction

    // Load-use: hold PC/IF/ID, bubble into EX (6'b000111)
    localparam logic [STALL_BUS_W-1:0] STALL_LU   = hold_through(STG_ID);
    // Multi-cycle: hold PC/IF/ID/EX, bubble into MEM (6'b001111)
    localparam logic [STALL_BUS_W-1:0] STALL_MC   = hold_through(STG_EX);
    localparam logic [STALL_BUS_W-1:0] STALL_NONE = {STALL_BUS_W{NOSTOP}};

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t RUN      = 2'd0;
    localparam state_t LU_GUARD = 2'd1;
    localparam state_t MC_WAIT  = 2'd2;

    // Width of the multi-cycle watchdog counter
    localparam int WD_W = 7;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // Reset and clear both zero the count; otherwise step up until all-ones
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall sequencer. Arbitrates the ID load-use bubble against
// the multi-cycle EX unit and drives the StallBus combinationally from the
// current state, so a hazard stalls the pipe in the same cycle it is raised.
// Also keeps a saturating count of stalled cycles for performance debug.
//
// Optional feature: define PIPE_STALL_MC_TIMEOUT_EN to build a watchdog that
// releases MC_WAIT after MC_TIMEOUT stalled cycles and pulses mc_timeout.
// Without it mc_timeout is tied low and MC_WAIT exits only on ex_mc_done.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W    = STALL_BUS_W,
    parameter int CNT_W      = 32
`ifdef PIPE_STALL_MC_TIMEOUT_EN
  , parameter int MC_TIMEOUT = 64
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_ld_stallreq,
    input  logic               ex_mc_start,
    input  logic               ex_mc_done,
    output logic [STALL_W-1:0] stall,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               mc_timeout
);

    state_t state;
    state_t state_next;

`ifdef PIPE_STALL_MC_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MC_TIMEOUT - 1);

    logic [WD_W-1:0] wd_count;
    logic            wd_fire;
`endif

    // Next-state and StallBus decode; stall depends on state and live inputs
    always_comb begin
        state_next = state;
        stall      = '0;
`ifdef PIPE_STALL_MC_TIMEOUT_EN
        wd_fire    = 1'b0;
`endif
        case (state)
            RUN: begin
                if (ex_mc_start && ex_mc_done) begin
                    // Result ready immediately: nothing to wait for
                    state_next = RUN;
                end else if (ex_mc_start) begin
                    stall      = STALL_W'(STALL_MC);
                    state_next = MC_WAIT;
                end else if (id_ld_stallreq) begin
                    stall      = STALL_W'(STALL_LU);
                    state_next = LU_GUARD;
                end
            end
            LU_GUARD: begin
                // The load has reached MEM and is forwarded, so the still-high
                // load-use request from ID must not insert a second bubble.
                if (ex_mc_start) begin
                    stall      = STALL_W'(STALL_MC);
                    state_next = MC_WAIT;
                end else begin
                    state_next = RUN;
                end
            end
            MC_WAIT: begin
                // Release in the done cycle itself so the result moves on
                if (ex_mc_done) begin
                    state_next = RUN;
                end
`ifdef PIPE_STALL_MC_TIMEOUT_EN
                else if (wd_count == WD_LIMIT) begin
                    state_next = RUN;
                    wd_fire    = 1'b1;
                end
`endif
                else begin
                    stall = STALL_W'(STALL_MC);
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Performance counter: one tick for every cycle the StallBus is non-zero
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (|stall),
        .count(stall_cycles)
    );

`ifdef PIPE_STALL_MC_TIMEOUT_EN
    // Watchdog: restarts on every entry to MC_WAIT, counts cycles spent there
    sat_counter #(
        .W(WD_W)
    ) u_wd_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state != MC_WAIT) && (state_next == MC_WAIT)),
        .en   (state == MC_WAIT),
        .count(wd_count)
    );

    // Registered one-cycle timeout pulse, following the forced release
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_timeout <= 1'b0;
        end else begin
            mc_timeout <= wd_fire;
        end
    end
`else
    assign mc_timeout = 1'b0;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline stall sequencer. It drives the StallBus consumed by every pipeline register (PC, IF, ID, EX, MEM, WB).
- Arbitrates two hazard sources: a one-cycle load-use bubble requested by ID, and a multi-cycle EX unit (mul/div) that holds the front of the pipe until it finishes.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- STALL_W, 6, StallBus width; bit i maps to stage i: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- CNT_W, 32, width of the stall-cycle counter.
- MC_TIMEOUT, 64, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_ld_stallreq  in  1  ID operand depends on a load currently in EX.
- ex_mc_start  in  1  one-cycle pulse: EX issues a multi-cycle op.
- ex_mc_done  in  1  one-cycle pulse: the multi-cycle result is valid this cycle.
- stall  out  STALL_W  per-stage hold; Stop = 1, NoStop = 0.
- stall_cycles  out  CNT_W  count of cycles with stall != 0.
- mc_timeout  out  1  watchdog pulse; tied 0 when the feature is absent.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- On reset: state = RUN, stall = 0, stall_cycles = 0, mc_timeout = 0.
- Reset asserted mid-operation (including during MC_WAIT) aborts immediately. stall is 0 in the cycle after reset is sampled.
- stall is combinational from the current state and inputs, giving zero-cycle response. All other outputs are registered.
- Bubble convention: a stage with stall[i] = 1 and stall[i+1] = 0 loads zeros into its output register.
- Load-use pattern LU = 6'b000111: hold PC/IF/ID, bubble into EX.
- Multi-cycle pattern MC = 6'b001111: hold PC/IF/ID/EX, bubble into MEM.
- FSM states and transitions:
  - RUN:
    - ex_mc_start = 1: stall = MC, next state MC_WAIT. ex_mc_start has priority over id_ld_stallreq; MC is a superset of LU.
    - else id_ld_stallreq = 1: stall = LU, next state LU_GUARD.
    - else: stall = 0, stay in RUN.
  - LU_GUARD (exactly one cycle):
    - stall = 0; id_ld_stallreq is ignored. The load is now in MEM and is covered by MEM forwarding.
    - ex_mc_start = 1: stall = MC, next state MC_WAIT.
    - else: next state RUN.
  - MC_WAIT:
    - ex_mc_done = 0: stall = MC, stay.
    - ex_mc_done = 1: stall = 0 in the same cycle, next state RUN.
    - ex_mc_start pulses here are ignored (illegal; assertion in bench).
- ex_mc_start and ex_mc_done high together in RUN: the unit is treated as zero-latency. stall = 0, stay in RUN.
- stall_cycles: +1 on every clock edge where stall != 0. Saturates at all-ones with no wrap.

Optional Feature:
- Macro: PIPE_STALL_MC_TIMEOUT_EN.
- Defined:
  - A 7-bit counter clears on entry to MC_WAIT and increments each cycle in MC_WAIT.
  - When it reaches MC_TIMEOUT-1 without ex_mc_done: stall = 0 that cycle, next state RUN, and mc_timeout pulses high for one cycle (registered).
- Not defined: mc_timeout is tied 0, no counter is built, and MC_WAIT exits only on ex_mc_done.

Decomposition:
- Shared defines header holds:
  - StallBus width and the Stop/NoStop values.
  - Stage index constants STG_PC through STG_WB.
  - The LU and MC pattern constants.
  - The FSM state encoding: RUN = 2'd0, LU_GUARD = 2'd1, MC_WAIT = 2'd2.
- One sub-module, sat_counter (parameterised width, enable, synchronous clear). It is used for stall_cycles and for the watchdog.

Test Plan:
- Reset then idle: rst held 2 cycles, then all inputs 0 -> stall = 6'b000000, stall_cycles = 0 for 10 cycles.
- Load-use: id_ld_stallreq held high 2 cycles from RUN -> stall = 6'b000111 for cycle 1, 6'b000000 for cycle 2 (LU_GUARD), then RUN; stall_cycles = 1.
- Multi-cycle: ex_mc_start pulse, ex_mc_done 33 cycles later -> stall = 6'b001111 for 33 cycles, 0 on the done cycle; stall_cycles = 33.
- Priority: ex_mc_start and id_ld_stallreq both high in RUN -> stall = 6'b001111, state MC_WAIT. Separately, ex_mc_start and ex_mc_done together -> stall = 0, stay RUN.
- Reset mid-MC: rst at cycle 5 of MC_WAIT -> next cycle stall = 0, stall_cycles = 0; a later ex_mc_done is ignored.
- Timeout (macro defined, MC_TIMEOUT = 64): ex_mc_start, no done -> stall released after 64 stalled cycles, mc_timeout is 1 for exactly one cycle, state RUN.
